// File: rtl/contador16_ctrl.sv
// contador16_ctrl: command sequencer for the 16-bit cascaded counter.
// Takes one command (mode, preload value, cycle count) over valid/ready, preloads
// the counter, runs it for the requested number of enabled cycles, then reports
// the final Q and how many full-width wraps (RCO[3]) were seen.
// Optional build macro: CONTADOR_CTRL_STOP_RCO_EN -- a full wrap during RUN ends
// the run early, exactly like abort.
module contador16_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CYC_W  = 16,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_modo,
  input  logic [WIDTH-1:0]  cmd_dato,
  input  logic [CYC_W-1:0]  cmd_ciclos,
  input  logic              abort,
  output logic              enb,
  output logic [1:0]        modo,
  output logic [WIDTH-1:0]  D,
  input  logic [WIDTH-1:0]  Q,
  input  logic [3:0]        RCO,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  q_final,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [1:0]        MODO_HOLD = 2'b00;
  localparam logic [1:0]        MODO_LOAD = 2'b11;
  localparam logic [WRAP_W-1:0] WRAP_MAX  = {WRAP_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         modo_q;
  logic [CYC_W-1:0]   run_cnt;
  logic               accept_c;
  logic               stop_c;
  logic               wrap_inc_c;
  logic               enb_nxt;
  logic [1:0]         modo_nxt;
  logic               unused_rco_c;

  // Only the top-stage carry matters here; lower stage carries are not used.
  assign unused_rco_c = ^RCO[2:0];

  // Early stop on a full wrap while running (optional build feature).
`ifdef CONTADOR_CTRL_STOP_RCO_EN
  assign stop_c = RCO[3];
`else
  assign stop_c = 1'b0;
`endif

  // Wraps are counted while the counter runs and in the settle cycle, saturating.
  assign wrap_inc_c = ((state == RUN) || (state == DONE)) && RCO[3] && (wrap_cnt != WRAP_MAX);

  // Next-state and next-value decode for the counter control lines.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    enb_nxt   = 1'b0;
    modo_nxt  = MODO_HOLD;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept_c  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if ((modo_q == MODO_LOAD) || (run_cnt == '0)) state_nxt = DONE;
        else                                          state_nxt = RUN;
      end
      RUN: begin
        if ((run_cnt == CYC_W'(1)) || abort || stop_c) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    case (state_nxt)
      LOAD: begin
        enb_nxt  = 1'b1;
        modo_nxt = MODO_LOAD;
      end
      RUN: begin
        enb_nxt  = 1'b1;
        modo_nxt = modo_q;
      end
      default: begin
        enb_nxt  = 1'b0;
        modo_nxt = MODO_HOLD;
      end
    endcase
  end

  // State register and registered counter-control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      enb       <= 1'b0;
      modo      <= MODO_HOLD;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      enb       <= enb_nxt;
      modo      <= modo_nxt;
      cmd_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
    end
  end

  // Command latch: D holds the preload value for the whole command; run counter counts down RUN cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      D       <= '0;
      modo_q  <= MODO_HOLD;
      run_cnt <= '0;
    end else if (accept_c) begin
      D       <= cmd_dato;
      modo_q  <= cmd_modo;
      run_cnt <= cmd_ciclos;
    end else if (state == RUN) begin
      run_cnt <= run_cnt - CYC_W'(1);
    end
  end

  // Result capture on leaving DONE, plus the saturating wrap counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      q_final  <= '0;
      wrap_cnt <= '0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) q_final <= Q;
      if (accept_c)        wrap_cnt <= '0;
      else if (wrap_inc_c) wrap_cnt <= wrap_cnt + WRAP_W'(1);
    end
  end

endmodule
